tick_pwm_generator: RTL and testbench
=====================================

Name: tick_pwm_generator

Overview:
- Consumes the divided clock produced by the clock-divider stage as a same-domain tick stream and generates a PWM waveform from it, e.g. for LED dimming and slow actuator drive.
- tick_in is a registered output on the same clock_in, so no synchronizer is needed.
- Block detects rising edges of tick_in and counts them modulo PERIOD.
- Output is high for a programmable number of ticks per period.

Parameters:
- WIDTH, 8, width of duty, tick_count and the internal step counter.
- PERIOD, 8'd10, ticks per PWM period; legal range 2..2^WIDTH-1.

Ports:
- clock_in  input  1  system clock; same clock that drives the divider.
- reset  input  1  synchronous, active-high reset, sampled on posedge clock_in.
- tick_in  input  1  divided clock from the divider stage, treated as data.
- enable  input  1  run request; level-sensitive.
- duty  input  WIDTH  requested high-ticks per period; sampled only at period start.
- pwm_out  output  1  PWM waveform, registered.
- period_done  output  1  one-cycle pulse marking completion of a full period, registered.
- tick_count  output  WIDTH  current step within the period (0..PERIOD-1), registered.

Behaviour:
- One clock (clock_in). Reset is synchronous and active-high. All state updates on posedge clock_in.
- Reset values:
  - pwm_out=0, period_done=0, tick_count=0.
  - tick_prev=0, duty_lat=0, state=IDLE.
  - Reset overrides all other inputs in the same cycle.
- Edge detect:
  - tick_prev <= tick_in every cycle, including in IDLE.
  - tick_rise = tick_in & ~tick_prev (combinational).
  - After reset, a tick_in already high produces one tick_rise on the first post-reset cycle.
- State machine:
  - IDLE: tick_count held at 0, pwm_out driven 0. When enable=1, go to RUN, latch duty_lat<=duty, tick_count stays 0.
  - RUN, enable=0: go to IDLE next cycle; tick_count<=0; pwm_out<=0. No period_done is issued for the partial period.
  - RUN, enable=1 and tick_rise=1:
    - If tick_count==PERIOD-1: tick_count<=0, duty_lat<=duty (new period), period_done<=1.
    - Otherwise: tick_count<=tick_count+1.
  - RUN, enable=1 and tick_rise=0: hold.
- Output:
  - pwm_out <= (state==RUN) && (tick_count < duty_lat), evaluated on current registered values.
  - pwm_out therefore lags tick_count by one clock.
  - Compare is unsigned. duty >= PERIOD gives a constant-high output while in RUN. duty=0 gives constant low.
- period_done:
  - High for exactly one cycle per wrap, else 0.
  - Asserts in the cycle tick_count shows 0 after the wrap.
- Duty changes mid-period are ignored until the next wrap or the next IDLE->RUN transition. This guarantees glitch-free periods.
- enable and tick_rise in the same cycle as IDLE->RUN: the tick is not counted; counting starts with the next rise.
- Reset mid-period: the partial period is discarded, with no period_done; outputs follow the reset values next cycle.
- No wrap beyond PERIOD-1; tick_count never exceeds PERIOD-1.

Test Plan:
- Reset with tick_in toggling, enable=1 -> pwm_out=0, tick_count=0, period_done=0 for every cycle reset is held.
- PERIOD=4, duty=1, tick_in toggling every clock (divisor 2, rise every 2 clocks) -> period is 8 clocks; pwm_out high 2 clocks, low 6; period_done pulses every 8 clocks; tick_count sequence 0,0,1,1,2,2,3,3.
- PERIOD=4; duty=0, then duty=4, then duty=9 -> pwm_out constantly 0, then constantly 1, then constantly 1 across 3 full periods; period_done still pulses each period.
- PERIOD=4, duty=1; change duty to 3 while tick_count=1 -> current period keeps 1 high tick; the next period shows 3 high ticks.
- Deassert enable while tick_count=2 -> next cycle tick_count=0 and pwm_out=0, no period_done. Re-enable -> first rise moves tick_count to 1.
- tick_in held high, then held low for 20 clocks -> no tick_rise, tick_count frozen, pwm_out constant at its last value.

Source files
------------

// File: rtl/tick_pwm_generator.sv
// PWM generator driven by a same-domain tick stream: counts rising edges of
// tick_in modulo PERIOD and holds pwm_out high for duty_lat ticks per period.
module tick_pwm_generator #(
  parameter int                 WIDTH  = 8,
  parameter logic [WIDTH-1:0]   PERIOD = WIDTH'(10)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm_out,
  output logic             period_done,
  output logic [WIDTH-1:0] tick_count,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] LAST_STEP = PERIOD - WIDTH'(1);

  state_t           state;
  state_t           state_next;
  logic             tick_prev;
  logic             tick_rise;
  logic [WIDTH-1:0] duty_lat;
  logic [WIDTH-1:0] duty_next;
  logic [WIDTH-1:0] count_next;
  logic             pwm_next;
  logic             done_next;

  // tick_in is a registered signal on clock_in, so plain edge detection is safe.
  assign tick_rise = tick_in & ~tick_prev;
  assign state_dbg = state;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state       <= IDLE;
      tick_prev   <= 1'b0;
      duty_lat    <= '0;
      tick_count  <= '0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      state       <= state_next;
      tick_prev   <= tick_in;
      duty_lat    <= duty_next;
      tick_count  <= count_next;
      pwm_out     <= pwm_next;
      period_done <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    duty_next  = duty_lat;
    count_next = tick_count;
    pwm_next   = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        count_next = '0;
        // A tick coinciding with the start request is deliberately not counted.
        if (enable) begin
          state_next = RUN;
          duty_next  = duty;
        end
      end
      RUN: begin
        if (!enable) begin
          // Partial period is abandoned without a period_done.
          state_next = IDLE;
          count_next = '0;
        end else begin
          pwm_next = (tick_count < duty_lat);
          if (tick_rise) begin
            if (tick_count == LAST_STEP) begin
              count_next = '0;
              duty_next  = duty;
              done_next  = 1'b1;
            end else begin
              count_next = tick_count + WIDTH'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tick_pwm_generator.sv
// Randomized and directed bench for tick_pwm_generator against a period-level
// reference model; expected outputs go through a queue checked by a monitor.
module tb_tick_pwm_generator;
  localparam int W = 8;
  localparam int P = 4;

  logic         clock_in = 1'b0;
  logic         reset    = 1'b1;
  logic         tick_in  = 1'b0;
  logic         enable   = 1'b0;
  logic [W-1:0] duty     = '0;
  logic         pwm_out;
  logic         period_done;
  logic [W-1:0] tick_count;
  logic         state_dbg;

  always #5 clock_in = ~clock_in;

  tick_pwm_generator #(.WIDTH(W), .PERIOD(8'd4)) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .tick_in     (tick_in),
    .enable      (enable),
    .duty        (duty),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .tick_count  (tick_count),
    .state_dbg   (state_dbg)
  );

  // Expected entry packing: {pwm, done, count}
  logic [W+1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: running flag, rises counted since the run started,
  // duty captured at each period boundary, previous tick level.
  bit m_run   = 0;
  int m_rises = 0;
  int m_duty  = 0;
  bit m_prev  = 0;
  bit tk      = 0;

  function automatic int m_step();
    return m_rises % P;
  endfunction

  task automatic cycle(input logic r, input logic t, input logic e, input logic [W-1:0] d);
    bit e_pwm;
    bit e_done;
    bit rise;
    @(negedge clock_in);
    reset = r; tick_in = t; enable = e; duty = d;
    e_pwm = 0; e_done = 0;
    if (r) begin
      m_run = 0; m_rises = 0; m_duty = 0; m_prev = 0;
    end else begin
      rise  = t && !m_prev;
      e_pwm = m_run && e && (m_step() < m_duty);
      if (!m_run) begin
        if (e) begin m_run = 1; m_rises = 0; m_duty = int'(d); end
      end else if (!e) begin
        m_run = 0; m_rises = 0;
      end else if (rise) begin
        m_rises++;
        if (m_step() == 0) begin e_done = 1; m_duty = int'(d); end
      end
      m_prev = t;
    end
    exp_q.push_back({e_pwm, e_done, W'(m_step())});
  endtask

  task automatic toggle_run(input int n, input logic e, input logic [W-1:0] d);
    for (int i = 0; i < n; i++) begin
      tk = ~tk;
      cycle(1'b0, tk, e, d);
    end
  endtask

  // Toggle ticks until the model reaches the wanted step; bounded.
  task automatic run_to_step(input int s, input logic [W-1:0] d);
    int guard;
    guard = 0;
    while (m_step() != s && guard < 64) begin
      toggle_run(1, 1'b1, d);
      guard++;
    end
    n_cmp++;
    if (m_step() != s) begin
      n_bad++;
      $display("FAIL run_to_step: reached %0d required %0d", m_step(), s);
    end
  endtask

  // Monitor: every clock is an output cycle; compare whenever an entry exists.
  initial begin
    logic [W+1:0] e;
    forever begin
      @(posedge clock_in);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp += 3;
        if (pwm_out !== e[W+1]) begin
          n_bad++;
          $display("FAIL pwm_out t=%0t: got %b want %b", $time, pwm_out, e[W+1]);
        end
        if (period_done !== e[W]) begin
          n_bad++;
          $display("FAIL period_done t=%0t: got %b want %b", $time, period_done, e[W]);
        end
        if (tick_count !== e[W-1:0]) begin
          n_bad++;
          $display("FAIL tick_count t=%0t: got %0d want %0d", $time, tick_count, e[W-1:0]);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] rd;
    logic         rr, rt, re;

    // Reset held while ticks toggle and enable is requested.
    for (int i = 0; i < 6; i++) begin
      tk = ~tk;
      cycle(1'b1, tk, 1'b1, W'($urandom_range(0, 9)));
    end

    // duty=1, rise every two clocks: 8-clock periods.
    tk = 0;
    toggle_run(26, 1'b1, 8'd1);

    // Constant-low, then constant-high for duty at and above PERIOD.
    toggle_run(32, 1'b1, 8'd0);
    toggle_run(32, 1'b1, 8'd4);
    toggle_run(32, 1'b1, 8'd9);

    // Mid-period duty change is deferred to the next wrap.
    toggle_run(24, 1'b1, 8'd1);
    run_to_step(1, 8'd1);
    toggle_run(24, 1'b1, 8'd3);

    // Drop enable at step 2, idle a while, then restart.
    run_to_step(2, 8'd3);
    cycle(1'b0, tk, 1'b0, 8'd3);
    toggle_run(5, 1'b0, 8'd3);
    toggle_run(12, 1'b1, 8'd2);

    // Tick frozen high, then low: no counting, pwm steady.
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1, 8'd2);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 8'd2);

    // Reset mid-period with tick already high.
    run_to_step(3, 8'd2);
    cycle(1'b1, 1'b1, 1'b1, 8'd2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 8'd2);

    // Random traffic.
    rd = 8'd2;
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 79) == 0);
      rt = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 9) == 0) rd = W'($urandom_range(0, 6));
      cycle(rr, rt, re, rd);
    end

    cycle(1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge clock_in);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
